pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, cycles pll_rst is held high per attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, cycles allowed for lock per attempt (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024, consecutive synced-locked cycles required before release (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, extra attempts after the first timeout before failing (0..255).
REQ-005 SHALL have port refclk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port locked  input  1  PLL lock, asynchronous to refclk.
REQ-008 SHALL have port restart  input  1  synchronous single-cycle request to re-run the sequence.
REQ-009 SHALL have port pll_rst  output  1  reset to the PLL.
REQ-010 SHALL have port core_reset  output  1  reset to downstream logic.
REQ-011 SHALL have port ready  output  1  high only in RUN.
REQ-012 SHALL have port fail  output  1  high only in FAIL.
REQ-013 SHALL have port lock_lost  output  1  one-cycle pulse on loss of lock in RUN.
REQ-014 SHALL have port loss_count  output  8  saturating count of lock_lost events.
REQ-015 SHALL have port state  output  3  encoding RST=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4.

Function
REQ-016 SHALL synchronise locked through two flops (locked_s), 2-cycle latency; all decisions use locked_s.
REQ-017 SHALL register every output and derive it from the next state, so outputs change on the same edge as the state.
REQ-018 RST SHALL drive pll_rst=1, count RST_CYCLES cycles, then go to WAIT with the counter cleared.
REQ-019 WAIT SHALL drive pll_rst=0; locked_s=1 -> SETTLE with the counter cleared; otherwise, when the counter reaches LOCK_TIMEOUT-1: retries<MAX_RETRIES -> retries+1 and RST, else FAIL.
REQ-020 SETTLE SHALL go to WAIT on locked_s=0 with the counter and timeout restarted; on the cycle the counter reaches SETTLE_CYCLES-1 with locked_s=1, it SHALL go to RUN.
REQ-021 RUN SHALL drive core_reset=0, ready=1 and clear retries; locked_s=0 -> RST, lock_lost=1 for one cycle, loss_count+1 saturating at 255.
REQ-022 FAIL SHALL hold pll_rst=1, core_reset=1, fail=1 and leave only on restart or rst.
REQ-023 core_reset SHALL be 1 in every state except RUN, and rise on the edge that leaves RUN.
REQ-024 restart=1 SHALL force RST with counter and retries cleared in any state, with priority over all other transitions; loss_count SHALL be kept.
REQ-025 Counter width SHALL be $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and SETTLE_CYCLES, plus 1, and SHALL never wrap.
REQ-026 Undefined state encodings SHALL recover to RST.

Reset
REQ-027 rst SHALL asynchronously set: state=RST, pll_rst=1, core_reset=1, ready=0, fail=0, lock_lost=0, loss_count=0, retries=0, counter=0, sync flops=0.
REQ-028 Release of rst SHALL start a full RST phase; assertion of rst mid-sequence SHALL abort it immediately, without a lock_lost pulse.

Configuration
REQ-029 With macro PLL_SEQ_TIMEOUT_EN defined, the WAIT timeout, retries and FAIL state SHALL be implemented as specified.
REQ-030 Without PLL_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely for locked_s, FAIL SHALL be unreachable, fail SHALL be tied to 0, and LOCK_TIMEOUT and MAX_RETRIES SHALL be ignored.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2, macro defined)
REQ-031 Normal bring-up: rst released, locked rises 3 cycles after pll_rst falls -> SETTLE 2 cycles later, ready=1 and core_reset=0 exactly 8 cycles after SETTLE entry.
REQ-032 Settle glitch: locked low for 1 cycle during SETTLE cycle 5 -> back to WAIT, then 8 fresh settle cycles are required before RUN.
REQ-033 Timeout/fail: locked held 0 -> three RST/WAIT attempts of 4+20 cycles each, then state=4, fail=1, pll_rst=1; a restart pulse -> state=0, fail=0.
REQ-034 Lock loss: locked drops in RUN -> lock_lost is high for 1 cycle 2 cycles later, core_reset=1 on the same edge, loss_count=1, sequence reruns; 300 losses -> loss_count=255.
REQ-035 Async reset mid-SETTLE: rst pulsed between clock edges -> all outputs reach reset values without waiting for a refclk edge, and lock_lost stays 0.
REQ-036 Macro undefined: locked held 0 for 1000 cycles -> state stays 1, fail=0, pll_rst=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Brings a PLL out of reset and holds downstream logic in reset until the PLL
// has reported a stable lock. Sequence: RST (pll_rst pulse) -> WAIT (for lock)
// -> SETTLE (lock must stay up for SETTLE_CYCLES) -> RUN. Losing lock in RUN
// restarts the sequence and is counted.
//
// Optional feature macro: PLL_SEQ_TIMEOUT_EN
//   defined   : WAIT times out after LOCK_TIMEOUT cycles, retries up to
//               MAX_RETRIES extra attempts, then parks in FAIL.
//   undefined : WAIT waits forever, FAIL is unreachable, fail is tied low.
//
// Ports
//   refclk     in   sole clock
//   rst        in   asynchronous active-high reset
//   locked     in   PLL lock indication, asynchronous to refclk
//   restart    in   single-cycle request to re-run the sequence
//   pll_rst    out  reset to the PLL
//   core_reset out  reset to downstream logic (low only in RUN)
//   ready      out  high only in RUN
//   fail       out  high only in FAIL
//   lock_lost  out  one-cycle pulse when lock drops in RUN
//   loss_count out  saturating count of lock_lost events
//   state      out  current state (RST=0 WAIT=1 SETTLE=2 RUN=3 FAIL=4)
//
// Handshake: none; restart is a plain synchronous level sampled every cycle
// and takes priority over every other transition.

module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int MAX_RS  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // Reject out-of-range configurations at elaboration.
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || SETTLE_CYCLES < 1 ||
        MAX_RETRIES < 0 || MAX_RETRIES > 255) begin : g_bad_params
        $error("pll_lock_sequencer: parameter out of range");
    end

    // Two-flop synchroniser for the asynchronous lock input.
    logic          locked_meta_q, locked_s_q;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pll_rst_q, pll_rst_d;
    logic          core_reset_q, core_reset_d;
    logic          ready_q, ready_d;
    logic          lock_lost_q, lock_lost_d;
    logic [7:0]    loss_count_q, loss_count_d;

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

    logic [7:0] retries_q, retries_d;
    logic       fail_q, fail_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lock_lost_d  = 1'b0;
        loss_count_d = loss_count_q;
`ifdef PLL_SEQ_TIMEOUT_EN
        retries_d    = retries_q;
`endif
        if (restart) begin
            state_d = ST_RST;
            cnt_d   = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
            retries_d = '0;
`endif
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (locked_s_q) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end
`ifdef PLL_SEQ_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retries_q < RETRY_LIMIT) begin
                            retries_d = retries_q + 8'd1;
                            state_d   = ST_RST;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                    // Without the timeout the counter simply rests at zero.
                end
                ST_SETTLE: begin
                    // Any dropout restarts both the settle window and the
                    // lock timeout.
                    if (!locked_s_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef PLL_SEQ_TIMEOUT_EN
                    retries_d = '0;
`endif
                    if (!locked_s_q) begin
                        state_d      = ST_RST;
                        cnt_d        = '0;
                        lock_lost_d  = 1'b1;
                        loss_count_d = (loss_count_q == 8'hff) ? 8'hff
                                                               : loss_count_q + 8'd1;
                    end
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                ST_FAIL: begin
                    // Parked until restart or rst.
                end
`endif
                default: begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are functions of the next state so they move with it.
        pll_rst_d    = (state_d == ST_RST) || (state_d == ST_FAIL);
        core_reset_d = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
        fail_d       = (state_d == ST_FAIL);
`endif
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            state_q       <= ST_RST;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            core_reset_q  <= 1'b1;
            ready_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
            loss_count_q  <= 8'd0;
`ifdef PLL_SEQ_TIMEOUT_EN
            retries_q     <= 8'd0;
            fail_q        <= 1'b0;
`endif
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            core_reset_q  <= core_reset_d;
            ready_q       <= ready_d;
            lock_lost_q   <= lock_lost_d;
            loss_count_q  <= loss_count_d;
`ifdef PLL_SEQ_TIMEOUT_EN
            retries_q     <= retries_d;
            fail_q        <= fail_d;
`endif
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_reset = core_reset_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;
    assign state      = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    assign fail       = fail_q;
`else
    assign fail       = 1'b0;
`endif

endmodule
